// File: rtl/rv32v_fetch2_stage.sv
// rv32v_fetch2_stage: producer side of the fetch2->decode interface. Classifies
//   imem responses (good / misaligned / faulting) into a 2-entry skid buffer.
//   Latency: push in cycle N visible at outputs in N+1. f1_ready = (count != 2).
// Ports: CLK, RST (sync, active-high); fetch1 side f1_valid/f1_ready/f1_pc/
//   f1_rdata/f1_fault; control flush; decode side dec_valid/dec_ready/instr/
//   mal_insn/fault_insn.
// Optional macro RV32V_FETCH2_TB_LINE_EN adds tb_line_num (pop counter) and
//   per-entry sequence tags with a pop-order assertion.

module rv32v_fetch2_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          DEPTH     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        f1_valid,
  output logic        f1_ready,
  input  logic [31:0] f1_pc,
  input  logic [31:0] f1_rdata,
  input  logic        f1_fault,
  input  logic        flush,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] instr,
  output logic        mal_insn,
`ifdef RV32V_FETCH2_TB_LINE_EN
  output logic        fault_insn,
  output logic [31:0] tb_line_num
`else
  output logic        fault_insn
`endif
);

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t rdata;
    logic  mal;
    logic  fault;
  } entry_t;

  // The pointer/count encoding below is hard-wired for two entries.
  if (DEPTH != 2) begin : g_bad_depth
    $error("rv32v_fetch2_stage: only DEPTH == 2 is supported");
  end

  logic [1:0] count_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  entry_t     entries_q [2];

  logic   push;
  logic   pop;
  entry_t new_entry;
  entry_t head;

  // Only the low PC bits matter for alignment classification.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, f1_pc[31:2]};

  assign f1_ready  = (count_q != 2'd2);
  assign dec_valid = (count_q != 2'd0);
  assign push      = f1_valid & f1_ready;
  assign pop       = dec_valid & dec_ready;

  // Fault has priority: a faulting fetch is never also flagged misaligned.
  always_comb begin
    new_entry.rdata = f1_rdata;
    new_entry.fault = f1_fault;
    new_entry.mal   = (f1_pc[1:0] != 2'b00) & ~f1_fault;
  end

  assign head = entries_q[rd_ptr_q];

  always_comb begin
    instr      = NOP_INSTR;
    mal_insn   = 1'b0;
    fault_insn = 1'b0;
    if (dec_valid) begin
      mal_insn   = head.mal;
      fault_insn = head.fault;
      if (!(head.mal || head.fault)) begin
        instr = head.rdata;
      end
    end
  end

  // Count / pointer state. Reset and flush both empty the buffer; flush
  // realigns rd_ptr to wr_ptr so stale contents are simply skipped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (flush) begin
      count_q  <= 2'd0;
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (push && !RST && !flush) begin
      entries_q[wr_ptr_q] <= new_entry;
    end
  end

`ifdef RV32V_FETCH2_TB_LINE_EN
  logic [7:0] tag_q [2];
  logic [7:0] push_seq_q;
  logic [7:0] pop_seq_q;

  always_ff @(posedge CLK) begin
    if (push && !RST && !flush) begin
      tag_q[wr_ptr_q] <= push_seq_q;
    end
  end

  // Pop counter survives flush; expected pop order skips flushed entries.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tb_line_num <= 32'd0;
      push_seq_q  <= 8'd0;
      pop_seq_q   <= 8'd0;
    end else begin
      if (pop) begin
        tb_line_num <= tb_line_num + 32'd1;
        assert (tag_q[rd_ptr_q] == pop_seq_q)
          else $error("rv32v_fetch2_stage: pop order tag %0d expected %0d",
                      tag_q[rd_ptr_q], pop_seq_q);
      end
      if (flush) begin
        pop_seq_q <= push_seq_q;
      end else begin
        if (push) push_seq_q <= push_seq_q + 8'd1;
        if (pop)  pop_seq_q  <= pop_seq_q + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv32v_fetch2_stage.sv
module tb_rv32v_fetch2_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        f1_valid;
  logic        f1_ready;
  logic [31:0] f1_pc;
  logic [31:0] f1_rdata;
  logic        f1_fault;
  logic        flush;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] instr;
  logic        mal_insn;
  logic        fault_insn;
`ifdef RV32V_FETCH2_TB_LINE_EN
  logic [31:0] tb_line_num;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  rv32v_fetch2_stage dut (
    .CLK(CLK), .RST(RST),
    .f1_valid(f1_valid), .f1_ready(f1_ready), .f1_pc(f1_pc),
    .f1_rdata(f1_rdata), .f1_fault(f1_fault), .flush(flush),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .instr(instr),
    .mal_insn(mal_insn),
`ifdef RV32V_FETCH2_TB_LINE_EN
    .fault_insn(fault_insn), .tb_line_num(tb_line_num)
`else
    .fault_insn(fault_insn)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d,
                       input logic f);
    f1_valid = v;
    f1_pc    = pc;
    f1_rdata = d;
    f1_fault = f;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step(); step();
    RST = 1'b0;

    // 1: reset / idle
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_f1_ready", {31'd0, f1_ready}, 32'd1);
    chk("rst_instr", instr, NOP);
    chk("rst_mal", {31'd0, mal_insn}, 32'd0);
    chk("rst_fault", {31'd0, fault_insn}, 32'd0);

    // 2: streaming with dec_ready high
    dec_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h00A0_0093, 1'b0);
    step();
    chk("s_vld1", {31'd0, dec_valid}, 32'd1);
    chk("s_instr1", instr, 32'h00A0_0093);
    chk("s_flags1", {30'd0, mal_insn, fault_insn}, 32'd0);
    chk("s_rdy1", {31'd0, f1_ready}, 32'd1);
    drive(1'b1, 32'h104, 32'h0020_8133, 1'b0);
    step();
    chk("s_instr2", instr, 32'h0020_8133);
    chk("s_vld2", {31'd0, dec_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("s_empty", {31'd0, dec_valid}, 32'd0);
    chk("s_empty_instr", instr, NOP);

    // 3: back-pressure
    dec_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h1111_1113, 1'b0);
    step();
    chk("bp_rdy1", {31'd0, f1_ready}, 32'd1);
    drive(1'b1, 32'h204, 32'h2222_2213, 1'b0);
    step();
    chk("bp_full_rdy", {31'd0, f1_ready}, 32'd0);
    drive(1'b1, 32'h208, 32'h3333_3313, 1'b0);
    step();
    chk("bp_hold_rdy", {31'd0, f1_ready}, 32'd0);
    chk("bp_head1", instr, 32'h1111_1113);
    dec_ready = 1'b1;
    step();
    chk("bp_head2", instr, 32'h2222_2213);
    chk("bp_rdy_again", {31'd0, f1_ready}, 32'd1);
    step();
    chk("bp_head3", instr, 32'h3333_3313);
    chk("bp_vld3", {31'd0, dec_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("bp_drained", {31'd0, dec_valid}, 32'd0);

    // 4: classification
    dec_ready = 1'b0;
    drive(1'b1, 32'h102, 32'h1234_5678, 1'b0);
    step();
    chk("mal_flag", {31'd0, mal_insn}, 32'd1);
    chk("mal_nofault", {31'd0, fault_insn}, 32'd0);
    chk("mal_instr", instr, NOP);
    dec_ready = 1'b1;
    drive(1'b1, 32'h103, 32'hDEAD_BEEF, 1'b1);
    step();
    chk("flt_flag", {31'd0, fault_insn}, 32'd1);
    chk("flt_nomal", {31'd0, mal_insn}, 32'd0);
    chk("flt_instr", instr, NOP);
    drive(1'b1, 32'h100, 32'hCAFE_0013, 1'b1);
    step();
    chk("flt_aligned", {30'd0, mal_insn, fault_insn}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("cls_drained", {31'd0, dec_valid}, 32'd0);

    // 5: flush at full, then reset at count 1
    dec_ready = 1'b0;
    drive(1'b1, 32'h300, 32'hAAAA_0013, 1'b0);
    step();
    drive(1'b1, 32'h304, 32'hBBBB_0013, 1'b0);
    step();
    chk("fl_full", {31'd0, f1_ready}, 32'd0);
    dec_ready = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h308, 32'hCCCC_0013, 1'b0);
    step();
    chk("fl_vld", {31'd0, dec_valid}, 32'd0);
    chk("fl_instr", instr, NOP);
    chk("fl_rdy", {31'd0, f1_ready}, 32'd1);
    flush = 1'b0; dec_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("fl_not_delivered", {31'd0, dec_valid}, 32'd0);
    drive(1'b1, 32'h400, 32'hDDDD_0013, 1'b0);
    step();
    chk("rst1_vld", {31'd0, dec_valid}, 32'd1);
    chk("rst1_instr", instr, 32'hDDDD_0013);
    RST = 1'b1;
    drive(1'b1, 32'h401, 32'hEEEE_0013, 1'b0);
    step();
    RST = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst2_vld", {31'd0, dec_valid}, 32'd0);
    chk("rst2_rdy", {31'd0, f1_ready}, 32'd1);
    chk("rst2_instr", instr, NOP);
    chk("rst2_flags", {30'd0, mal_insn, fault_insn}, 32'd0);
    step();
    chk("rst2_push_dropped", {31'd0, dec_valid}, 32'd0);

`ifdef RV32V_FETCH2_TB_LINE_EN
    // 6: pop counter across flush
    chk("line_rst", tb_line_num, 32'd0);
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 32'h0000_0013 + 32'(i << 8), 1'b0);
      step();
    end
    chk("line_5", tb_line_num, 32'd5);
    dec_ready = 1'b0; flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    flush = 1'b0;
    chk("line_after_flush", tb_line_num, 32'd5);
    dec_ready = 1'b1;
    drive(1'b1, 32'h600, 32'h0010_0013, 1'b0);
    step();
    drive(1'b1, 32'h604, 32'h0020_0013, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("line_7", tb_line_num, 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
